// File: rtl/cpu_pkg.sv
// Shared pipeline constants and the fetch-stage state type.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = '0;

    localparam int unsigned DEF_PC_W = 8;
    localparam int unsigned DEF_INC  = 4;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HOLD,
        ST_REDIR
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch: reset > bubble > load > hold.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = DEF_PC_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            bubble_i,
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] pc_next_i,
    output logic [31:0]     instr_o,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_next_o,
    output logic            valid_o
);

    logic [31:0]     instr_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_next_q;
    logic            valid_q;

    // A bubble clears only instr/valid; the pc fields keep their last value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            pc_next_q <= '0;
            valid_q   <= 1'b0;
        end else if (bubble_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q   <= instr_i;
            pc_q      <= pc_i;
            pc_next_q <= pc_next_i;
            valid_q   <= 1'b1;
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign pc_next_o = pc_next_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, ROM addressing, branch redirect with one bubble, stall hold
// and saturating debug counters.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W  = DEF_PC_W,
    parameter int unsigned INC   = DEF_INC,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             R,
    input  logic             LE,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic [31:0]      rom_instr,
    output logic [PC_W-1:0]  rom_addr,
    output logic [31:0]      if_id_instr,
    output logic [PC_W-1:0]  if_id_pc,
    output logic [PC_W-1:0]  if_id_pc_next,
    output logic             if_id_valid,
    output logic             stalled,
    output logic             redirected,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [PC_W-1:0] INC_V    = PC_W'(INC);
    localparam logic [PC_W-1:0] LOW_MASK = PC_W'(INC - 1);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  pc_inc;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             misalign_q, misalign_d;
    logic             do_fetch, do_stall;

    assign do_stall = !branch_taken && !LE;
    assign do_fetch = !branch_taken && LE;
    assign pc_inc   = pc_q + INC_V;

    always_comb begin
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        misalign_d    = misalign_q;
        if (branch_taken) begin
            pc_d       = branch_target & ~LOW_MASK;
            misalign_d = misalign_q | (|(branch_target & LOW_MASK));
        end else if (do_stall) begin
            if (stall_count_q != '1) stall_count_d = stall_count_q + 1'b1;
        end else begin
            pc_d = pc_inc;
            if (fetch_count_q != '1) fetch_count_d = fetch_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            pc_q          <= '0;
            fetch_count_q <= '0;
            stall_count_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
            misalign_q    <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        if (R) state_q <= ST_RUN;
        else   state_q <= state_d;
    end

    always_comb begin
        state_d = ST_RUN;
        if (branch_taken)  state_d = ST_REDIR;
        else if (!LE)      state_d = ST_HOLD;
    end

    always_comb begin
        stalled    = (state_q == ST_HOLD);
        redirected = (state_q == ST_REDIR);
    end

    if_id_reg #(
        .PC_W (PC_W)
    ) u_if_id (
        .clk_i     (clk),
        .rst_i     (R),
        .load_i    (do_fetch),
        .bubble_i  (branch_taken),
        .instr_i   (rom_instr),
        .pc_i      (pc_q),
        .pc_next_i (pc_inc),
        .instr_o   (if_id_instr),
        .pc_o      (if_id_pc),
        .pc_next_o (if_id_pc_next),
        .valid_o   (if_id_valid)
    );

    assign rom_addr     = pc_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        R = 1'b1, LE = 1'b0, branch_taken = 1'b0;
    logic [7:0]  branch_target = '0;
    logic [31:0] rom_instr, rom_instr2;
    logic [7:0]  rom_addr, rom_addr2;
    logic [31:0] if_id_instr, if_id_instr2;
    logic [7:0]  if_id_pc, if_id_pc2, if_id_pc_next, if_id_pc_next2;
    logic        if_id_valid, if_id_valid2, stalled, stalled2;
    logic        redirected, redirected2, misalign_err, misalign_err2;
    logic [15:0] fetch_count, stall_count;
    logic [1:0]  fetch_count2, stall_count2;

    logic [31:0] rom [256];

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          m_pc, m_ifpc, m_ifnext, m_fc, m_sc;
    logic [31:0] m_instr;
    bit          m_valid, m_stalled, m_redir, m_mis;

    always #5 clk = ~clk;

    always_comb rom_instr  = rom[rom_addr];
    always_comb rom_instr2 = rom[rom_addr2];

    fetch_stage #(.PC_W(8), .INC(4), .CNT_W(16)) dut (
        .clk(clk), .R(R), .LE(LE), .branch_taken(branch_taken),
        .branch_target(branch_target), .rom_instr(rom_instr), .rom_addr(rom_addr),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc_next(if_id_pc_next),
        .if_id_valid(if_id_valid), .stalled(stalled), .redirected(redirected),
        .misalign_err(misalign_err), .fetch_count(fetch_count), .stall_count(stall_count)
    );

    fetch_stage #(.PC_W(8), .INC(4), .CNT_W(2)) dut_sat (
        .clk(clk), .R(R), .LE(LE), .branch_taken(branch_taken),
        .branch_target(branch_target), .rom_instr(rom_instr2), .rom_addr(rom_addr2),
        .if_id_instr(if_id_instr2), .if_id_pc(if_id_pc2), .if_id_pc_next(if_id_pc_next2),
        .if_id_valid(if_id_valid2), .stalled(stalled2), .redirected(redirected2),
        .misalign_err(misalign_err2), .fetch_count(fetch_count2), .stall_count(stall_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic model_edge(input bit r, input bit le, input bit bt, input int tgt);
        if (r) begin
            m_pc = 0; m_instr = '0; m_ifpc = 0; m_ifnext = 0; m_valid = 0;
            m_stalled = 0; m_redir = 0; m_mis = 0; m_fc = 0; m_sc = 0;
        end else if (bt) begin
            m_pc = (tgt / 4) * 4;
            if (tgt % 4 != 0) m_mis = 1;
            m_instr = '0; m_valid = 0; m_redir = 1; m_stalled = 0;
        end else if (!le) begin
            m_stalled = 1; m_redir = 0; m_sc++;
        end else begin
            m_instr  = rom[m_pc];
            m_ifpc   = m_pc;
            m_ifnext = (m_pc + 4) % 256;
            m_valid  = 1;
            m_pc     = (m_pc + 4) % 256;
            m_stalled = 0; m_redir = 0; m_fc++;
        end
    endtask

    task automatic check_all();
        check("rom_addr",      rom_addr,      m_pc);
        check("if_id_instr",   if_id_instr,   m_instr);
        check("if_id_pc",      if_id_pc,      m_ifpc);
        check("if_id_pc_next", if_id_pc_next, m_ifnext);
        check("if_id_valid",   if_id_valid,   m_valid);
        check("stalled",       stalled,       m_stalled);
        check("redirected",    redirected,    m_redir);
        check("misalign_err",  misalign_err,  m_mis);
        check("fetch_count",   fetch_count,   sat(m_fc, 65535));
        check("stall_count",   stall_count,   sat(m_sc, 65535));
        check("fetch_count_w2", fetch_count2, sat(m_fc, 3));
        check("stall_count_w2", stall_count2, sat(m_sc, 3));
    endtask

    // Called at a negedge: drive, take one rising edge, sample on the next negedge.
    task automatic step(input bit r, input bit le, input bit bt, input int tgt);
        R = r; LE = le; branch_taken = bt; branch_target = tgt[7:0];
        @(posedge clk);
        model_edge(r, le, bt, tgt);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        @(negedge clk);

        // reset, then four fetches
        step(1, 0, 0, 0);
        check("rst_valid", if_id_valid, 0);
        check("rst_instr", if_id_instr, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        check("t1_instr", if_id_instr, rom[12]);
        check("t1_pc", if_id_pc, 8'd12);
        check("t1_fcnt", fetch_count, 16'd4);
        check("t1_stalled", stalled, 0);

        // stall three cycles with PC=8
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        check("t2_addr", rom_addr, 8'd8);
        check("t2_pc", if_id_pc, 8'd4);
        check("t2_instr", if_id_instr, rom[4]);
        check("t2_scnt", stall_count, 16'd3);
        check("t2_stalled", stalled, 1);
        step(0, 1, 0, 0);
        check("t2_resume_pc", if_id_pc, 8'd8);
        check("t2_resume_instr", if_id_instr, rom[8]);

        // branch while stalled
        step(0, 0, 1, 'h40);
        check("t3_addr", rom_addr, 8'h40);
        check("t3_valid", if_id_valid, 0);
        check("t3_redir", redirected, 1);
        step(0, 1, 0, 0);
        check("t3_instr", if_id_instr, rom[8'h40]);
        check("t3_pc", if_id_pc, 8'h40);

        // misaligned target
        step(0, 1, 1, 'h43);
        check("t4_addr", rom_addr, 8'h40);
        check("t4_mis", misalign_err, 1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 'h80);
        check("t4_mis_sticky", misalign_err, 1);

        // PC wrap
        step(0, 1, 1, 'hFC);
        step(0, 1, 0, 0);
        check("t5_pc", if_id_pc, 8'hFC);
        check("t5_pc_next", if_id_pc_next, 8'h00);
        check("t5_addr", rom_addr, 8'h00);

        // reset during hold, then CNT_W=2 saturation
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("t6_scnt", stall_count, 16'd0);
        check("t6_mis", misalign_err, 0);
        check("t6_stalled", stalled, 0);
        check("t6_addr", rom_addr, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        check("t6_sat", fetch_count2, 2'd3);
        check("t6_full", fetch_count, 16'd5);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
